// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared constants, tx state encoding and header builder for the router packet transmitter
package router_pkg;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 6;
    localparam int ADDR_W = 2;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    localparam logic [2:0] TX_IDLE    = 3'd0;
    localparam logic [2:0] TX_FILL    = 3'd1;
    localparam logic [2:0] TX_HEADER  = 3'd2;
    localparam logic [2:0] TX_PAYLOAD = 3'd3;
    localparam logic [2:0] TX_PARITY  = 3'd4;
    localparam logic [2:0] TX_GAP     = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = TX_IDLE,
        ST_FILL    = TX_FILL,
        ST_HEADER  = TX_HEADER,
        ST_PAYLOAD = TX_PAYLOAD,
        ST_PARITY  = TX_PARITY,
        ST_GAP     = TX_GAP
    } tx_state_t;

    // Header byte on the wire: length in the upper six bits, destination in the lower two.
    function automatic logic [DATA_W-1:0] build_header(input logic [LEN_W-1:0]  len,
                                                       input logic [ADDR_W-1:0] addr);
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// rtl/router_tx_buf.sv - 64x8 payload buffer, synchronous write, asynchronous read
// Ports:
//   clock            write clock
//   wr_en/wr_addr/wr_data   write port
//   rd_addr/rd_data         combinational read port
module router_tx_buf
    import router_pkg::*;
(
    input  logic              clock,
    input  logic              wr_en,
    input  logic [LEN_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [LEN_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<LEN_W)-1];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_pkt_tx.sv
// rtl/router_pkt_tx.sv - packet transmitter driving the router's pkt_valid/data_in/busy input port
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   start, dest_addr, payload_len, req_ready   packet request, accepted only in IDLE
//   src_data, src_valid, src_ready             upstream payload byte stream
//   busy                         router back-pressure; holds the current wire byte
//   pkt_valid, data_out          wire to the router
//   done                         pulse on the last gap cycle
//   err                          pulse one cycle after a rejected request
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int GAP_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic [LEN_W-1:0]  payload_len,
    output logic              req_ready,
    input  logic [DATA_W-1:0] src_data,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic              busy,
    output logic              pkt_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              done,
    output logic              err
);

    localparam int GAP_W = 8;

    tx_state_t         state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  wr_ptr;
    logic [LEN_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] parity;
    logic [GAP_W-1:0]  gap_cnt;
    logic              err_q;

    logic              req_ok;
    logic              wr_en;
    logic [DATA_W-1:0] rd_data;

    assign req_ok = (dest_addr != ADDR_INVALID) && (payload_len != '0);
    assign wr_en  = (state == ST_FILL) && src_valid;

    router_tx_buf u_buf (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (src_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            addr    <= '0;
            len     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            parity  <= '0;
            gap_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (req_ok) begin
                            addr   <= dest_addr;
                            len    <= payload_len;
                            parity <= build_header(payload_len, dest_addr);
                            wr_ptr <= '0;
                            state  <= ST_FILL;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    if (src_valid) begin
                        parity <= parity ^ src_data;
                        wr_ptr <= wr_ptr + 1'b1;
                        if (wr_ptr == len - 1'b1) begin
                            state <= ST_HEADER;
                        end
                    end
                end
                ST_HEADER: begin
                    if (!busy) begin
                        rd_ptr <= '0;
                        state  <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    // rd_ptr may step to len after the last byte; it is never read there.
                    if (!busy) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        if (rd_ptr == len - 1'b1) begin
                            state <= ST_PARITY;
                        end
                    end
                end
                ST_PARITY: begin
                    if (!busy) begin
                        gap_cnt <= GAP_W'(GAP_CYCLES);
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    // Counts down; the cycle showing 1 is the last gap cycle.
                    if (gap_cnt <= GAP_W'(1)) begin
                        gap_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (state == ST_IDLE);
    assign src_ready = (state == ST_FILL);
    assign pkt_valid = (state == ST_HEADER) || (state == ST_PAYLOAD);
    assign done      = (state == ST_GAP) && (gap_cnt == GAP_W'(1));
    assign err       = err_q;

    always_comb begin
        data_out = '0;
        case (state)
            ST_HEADER:  data_out = build_header(len, addr);
            ST_PAYLOAD: data_out = rd_data;
            ST_PARITY:  data_out = parity;
            default:    data_out = '0;
        endcase
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb/tb_router_pkt_tx.sv - randomized self-checking bench for router_pkt_tx
module tb_router_pkt_tx;

    localparam int GAP = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] payload_len;
    logic       req_ready;
    logic [7:0] src_data;
    logic       src_valid;
    logic       src_ready;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       done;
    logic       err;

    always #5 clock = ~clock;

    router_pkt_tx #(.GAP_CYCLES(GAP)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dest_addr   (dest_addr),
        .payload_len (payload_len),
        .req_ready   (req_ready),
        .src_data    (src_data),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .busy        (busy),
        .pkt_valid   (pkt_valid),
        .data_out    (data_out),
        .done        (done),
        .err         (err)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] pay [0:63];

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // src_mode: 0 continuous, 1 every other cycle, 2 random
    // busy_mode: 0 never, 1 random, 2 stall two cycles on wire byte 2
    // abort_idx: wire byte index at which reset is asserted (-1 none)
    task automatic send_packet(input int a, input int l, input int src_mode, input int busy_mode,
                               input int hold_start, input int abort_idx);
        logic [7:0] exp_b [0:65];
        logic [7:0] par;
        int idx, sent, fill_cyc, stall, guard;
        exp_b[0] = 8'(l * 4 + a);
        par = exp_b[0];
        for (int i = 0; i < l; i++) begin
            exp_b[i+1] = pay[i];
            par = par ^ pay[i];
        end
        exp_b[l+1] = par;

        expect_eq("req_ready_idle", 32'(req_ready), 1);
        start = 1'b1;
        dest_addr = 2'(a);
        payload_len = 6'(l);
        @(negedge clock);
        if (hold_start == 0) start = 1'b0;

        sent = 0; fill_cyc = 0; guard = 0;
        while (sent < l && guard < 400) begin
            expect_eq("fill_src_ready", 32'(src_ready), 1);
            expect_eq("fill_pkt_valid", 32'(pkt_valid), 0);
            expect_eq("fill_req_ready", 32'(req_ready), 0);
            if (hold_start != 0) begin
                dest_addr = 2'($urandom);
                payload_len = 6'($urandom);
            end
            case (src_mode)
                0:       src_valid = 1'b1;
                1:       src_valid = (fill_cyc % 2 == 0);
                default: src_valid = 1'($urandom_range(0, 1));
            endcase
            if (src_valid) begin
                src_data = pay[sent];
                sent++;
            end else begin
                src_data = 8'($urandom);
            end
            fill_cyc++;
            guard++;
            @(negedge clock);
        end
        src_valid = 1'b0;
        if (guard >= 400) expect_eq("fill_timeout", 0, 1);

        idx = 0; stall = 0; guard = 0;
        while (idx < l + 2 && guard < 1000) begin
            expect_eq($sformatf("wire_byte%0d", idx), 32'(data_out), 32'(exp_b[idx]));
            expect_eq($sformatf("wire_pkt_valid%0d", idx), 32'(pkt_valid), 32'(idx <= l));
            expect_eq("wire_src_ready", 32'(src_ready), 0);
            expect_eq("wire_done", 32'(done), 0);
            if (hold_start != 0) begin
                dest_addr = 2'($urandom);
                payload_len = 6'($urandom);
            end
            if (idx == abort_idx) begin
                reset = 1'b1;
                busy = 1'($urandom_range(0, 1));
                @(negedge clock);
                reset = 1'b0;
                busy = 1'b0;
                expect_eq("abort_pkt_valid", 32'(pkt_valid), 0);
                expect_eq("abort_req_ready", 32'(req_ready), 1);
                expect_eq("abort_src_ready", 32'(src_ready), 0);
                expect_eq("abort_data_out", 32'(data_out), 0);
                return;
            end
            case (busy_mode)
                0: busy = 1'b0;
                1: busy = ($urandom_range(0, 3) == 0);
                default: begin
                    busy = (idx == 2 && stall < 2);
                    if (busy) stall++;
                end
            endcase
            if (!busy) idx++;
            guard++;
            @(negedge clock);
        end
        busy = 1'b0;
        if (guard >= 1000) expect_eq("wire_timeout", 0, 1);

        for (int g = 0; g < GAP; g++) begin
            expect_eq("gap_pkt_valid", 32'(pkt_valid), 0);
            expect_eq("gap_data_out", 32'(data_out), 0);
            expect_eq("gap_req_ready", 32'(req_ready), 0);
            expect_eq($sformatf("gap_done%0d", g), 32'(done), 32'(g == GAP - 1));
            busy = 1'($urandom_range(0, 1));
            if (hold_start != 0) begin
                dest_addr = 2'($urandom);
                payload_len = 6'($urandom);
            end
            @(negedge clock);
        end
        busy = 1'b0;
        expect_eq("post_req_ready", 32'(req_ready), 1);
        expect_eq("post_done", 32'(done), 0);
        expect_eq("post_pkt_valid", 32'(pkt_valid), 0);
    endtask

    task automatic bad_req(input int a, input int l);
        expect_eq("bad_pre_err", 32'(err), 0);
        start = 1'b1;
        dest_addr = 2'(a);
        payload_len = 6'(l);
        @(negedge clock);
        start = 1'b0;
        expect_eq("bad_err", 32'(err), 1);
        expect_eq("bad_req_ready", 32'(req_ready), 1);
        expect_eq("bad_src_ready", 32'(src_ready), 0);
        expect_eq("bad_pkt_valid", 32'(pkt_valid), 0);
        @(negedge clock);
        expect_eq("bad_err_clear", 32'(err), 0);
        expect_eq("bad_src_ready2", 32'(src_ready), 0);
        expect_eq("bad_pkt_valid2", 32'(pkt_valid), 0);
    endtask

    task automatic fill_random(input int l);
        for (int i = 0; i < l; i++) pay[i] = 8'($urandom);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; dest_addr = '0; payload_len = '0;
        src_data = '0; src_valid = 1'b0; busy = 1'b0;
        repeat (2) @(negedge clock);
        expect_eq("rst_req_ready", 32'(req_ready), 1);
        expect_eq("rst_pkt_valid", 32'(pkt_valid), 0);
        expect_eq("rst_data_out", 32'(data_out), 0);
        expect_eq("rst_src_ready", 32'(src_ready), 0);
        expect_eq("rst_done", 32'(done), 0);
        expect_eq("rst_err", 32'(err), 0);
        reset = 1'b0;
        @(negedge clock);

        pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
        send_packet(1, 3, 0, 0, 0, -1);
        send_packet(1, 3, 0, 2, 0, -1);

        bad_req(3, 5);
        bad_req(1, 0);

        fill_random(63);
        send_packet(2, 63, 1, 0, 0, -1);
        fill_random(63);
        send_packet(0, 63, 2, 1, 0, -1);

        fill_random(5);
        send_packet(0, 5, 0, 0, 0, 2);
        pay[0] = 8'h55;
        send_packet(2, 1, 0, 0, 0, -1);

        for (int k = 0; k < 3; k++) begin
            fill_random(8);
            send_packet(k, 1 + k * 3, 0, 1, 1, -1);
        end
        start = 1'b0;
        @(negedge clock);

        for (int k = 0; k < 25; k++) begin
            int a, l;
            if ($urandom_range(0, 4) == 0) begin
                if ($urandom_range(0, 1) == 0) bad_req(3, $urandom_range(0, 63));
                else                           bad_req($urandom_range(0, 3), 0);
            end
            a = $urandom_range(0, 2);
            l = ($urandom_range(0, 5) == 0) ? 63 : $urandom_range(1, 20);
            fill_random(l);
            send_packet(a, l, 2, 1, 0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
